// File: rtl/escalonador_classificacao_pkg.sv
// Shared types and helpers for the classification scheduler.
package escalonador_classificacao_pkg;

  // Scheduler FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_OCIOSO    = 3'd0,
    ST_CAPTURAR  = 3'd1,
    ST_ATUALIZAR = 3'd2,
    ST_AGUARDAR  = 3'd3,
    ST_ASSENTAR  = 3'd4,
    ST_BUSCAR    = 3'd5,
    ST_ENTREGAR  = 3'd6
  } estado_t;

  // Widest criterion / packed vector the helper below can handle.
  localparam int CRITERIO_MAX_WIDTH = 32;
  localparam int VETOR_MAX_WIDTH    = 1024;

  // All-ones criterion: an inactive slot never wins a minimum search.
  localparam logic [CRITERIO_MAX_WIDTH-1:0] CRITERIO_INF = '1;

  // Extracts slot idx of width cw from a zero-padded packed vector.
  function automatic logic [CRITERIO_MAX_WIDTH-1:0] extrair_slot(
    input logic [VETOR_MAX_WIDTH-1:0] vetor,
    input int                         cw,
    input int                         idx
  );
    logic [VETOR_MAX_WIDTH-1:0]    desl;
    logic [CRITERIO_MAX_WIDTH-1:0] mascara;
    desl    = vetor >> (cw * idx);
    mascara = CRITERIO_INF >> (CRITERIO_MAX_WIDTH - cw);
    return desl[CRITERIO_MAX_WIDTH-1:0] & mascara;
  endfunction

endpackage

// File: rtl/escalonador_classificacao_if.sv
// Result channel from the scheduler to the expansion stage.
// Handshake: the master raises res_valido_o with index/criterion/empty flag
// and holds all of them stable until it sees res_ack_in high on a clock edge;
// that edge completes the transfer and res_valido_o drops on the next cycle.
interface escalonador_classificacao_if #(
  parameter int IDX_WIDTH      = 3,
  parameter int CRITERIO_WIDTH = 5
);
  logic                      res_valido_o;
  logic [IDX_WIDTH-1:0]      res_indice_o;
  logic [CRITERIO_WIDTH-1:0] res_criterio_o;
  logic                      res_vazio_o;
  logic                      res_ack_in;

  modport master (
    output res_valido_o, res_indice_o, res_criterio_o, res_vazio_o,
    input  res_ack_in
  );

  modport slave (
    input  res_valido_o, res_indice_o, res_criterio_o, res_vazio_o,
    output res_ack_in
  );
endinterface

// File: rtl/escalonador_classificacao_mascarar_criterio.sv
// Forces the criterion of every inactive slot to all-ones.
module mascarar_criterio
  import escalonador_classificacao_pkg::*;
#(
  parameter int NUM_NA         = 8,
  parameter int CRITERIO_WIDTH = 5
) (
  input  logic [NUM_NA-1:0]                ativo,
  input  logic [NUM_NA*CRITERIO_WIDTH-1:0] criterio,
  output logic [NUM_NA*CRITERIO_WIDTH-1:0] mascarado
);

  // Per-slot select between the raw criterion and the infinity value.
  always_comb begin
    mascarado = '0;
    for (int i = 0; i < NUM_NA; i++) begin
      mascarado[i*CRITERIO_WIDTH +: CRITERIO_WIDTH] =
        ativo[i] ? criterio[i*CRITERIO_WIDTH +: CRITERIO_WIDTH]
                 : CRITERIO_INF[CRITERIO_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/escalonador_classificacao.sv
// Sequences one classification run: snapshot, trigger classifier, wait for
// the settled minimum, scan for the lowest active index holding it, deliver.
module escalonador_classificacao
  import escalonador_classificacao_pkg::*;
#(
  parameter  int NUM_NA         = 8,
  parameter  int CRITERIO_WIDTH = 5,
  parameter  int LAT_EXTRA      = 2,
  parameter  int TIMEOUT        = 64,
  localparam int IDX_WIDTH      = $clog2(NUM_NA)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sol_iniciar_in,
  input  logic                             sol_cancelar_in,
  input  logic [NUM_NA-1:0]                na_ativo_in,
  input  logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_in,
  output logic                             ocupado_o,
  output logic                             aa_atualizar_o,
  output logic [NUM_NA-1:0]                na_ativo_o,
  output logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_o,
  input  logic                             ca_pronto_in,
  input  logic [CRITERIO_WIDTH-1:0]        ca_criterio_geral_in,
  escalonador_classificacao_if.master      res,
  output logic                             erro_timeout_o,
  output estado_t                          estado_o
);

  localparam int TO_WIDTH = $clog2(TIMEOUT + 1);

  estado_t                          estado;
  logic [NUM_NA-1:0]                snap_ativo;
  logic [NUM_NA*CRITERIO_WIDTH-1:0] snap_crit;
  logic [NUM_NA*CRITERIO_WIDTH-1:0] crit_mascarado;
  logic [TO_WIDTH-1:0]              cnt_timeout;
  logic [3:0]                       cnt_assentar;
  logic [IDX_WIDTH-1:0]             indice_busca;
  logic                             res_valido_r;
  logic [IDX_WIDTH-1:0]             res_indice_r;
  logic [CRITERIO_WIDTH-1:0]        res_criterio_r;
  logic                             res_vazio_r;
  logic [VETOR_MAX_WIDTH-1:0]       snap_pad;
  logic [CRITERIO_MAX_WIDTH-1:0]    slot_atual;
  logic                             slot_igual;

  mascarar_criterio #(
    .NUM_NA         (NUM_NA),
    .CRITERIO_WIDTH (CRITERIO_WIDTH)
  ) u_mascarar (
    .ativo     (na_ativo_in),
    .criterio  (na_criterio_in),
    .mascarado (crit_mascarado)
  );

  // Zero-pad the snapshot so the shared extraction helper can index it.
  always_comb begin
    snap_pad = '0;
    snap_pad[NUM_NA*CRITERIO_WIDTH-1:0] = snap_crit;
  end

  assign slot_atual = extrair_slot(snap_pad, CRITERIO_WIDTH, int'(indice_busca));
  assign slot_igual = (slot_atual == CRITERIO_MAX_WIDTH'(res_criterio_r));

  assign ocupado_o          = (estado != ST_OCIOSO);
  assign na_ativo_o         = snap_ativo;
  assign na_criterio_o      = snap_crit;
  assign estado_o           = estado;
  assign res.res_valido_o   = res_valido_r;
  assign res.res_indice_o   = res_indice_r;
  assign res.res_criterio_o = res_criterio_r;
  assign res.res_vazio_o    = res_vazio_r;

  // Scheduler FSM with registered outputs; cancel overrides everything but reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado         <= ST_OCIOSO;
      snap_ativo     <= '0;
      snap_crit      <= '1;
      cnt_timeout    <= '0;
      cnt_assentar   <= '0;
      indice_busca   <= '0;
      aa_atualizar_o <= 1'b0;
      erro_timeout_o <= 1'b0;
      res_valido_r   <= 1'b0;
      res_indice_r   <= '0;
      res_criterio_r <= '0;
      res_vazio_r    <= 1'b0;
    end else if (sol_cancelar_in) begin
      // Snapshot and last result data are kept; only control is dropped.
      estado         <= ST_OCIOSO;
      aa_atualizar_o <= 1'b0;
      erro_timeout_o <= 1'b0;
      res_valido_r   <= 1'b0;
    end else begin
      aa_atualizar_o <= 1'b0;
      erro_timeout_o <= 1'b0;
      case (estado)
        ST_OCIOSO: begin
          if (sol_iniciar_in) begin
            snap_ativo <= na_ativo_in;
            snap_crit  <= crit_mascarado;
            estado     <= ST_CAPTURAR;
          end
        end
        ST_CAPTURAR: begin
          aa_atualizar_o <= 1'b1;
          estado         <= ST_ATUALIZAR;
        end
        ST_ATUALIZAR: begin
          cnt_timeout <= '0;
          estado      <= ST_AGUARDAR;
        end
        ST_AGUARDAR: begin
          // A zero count marks the first cycle, where pronto may be stale.
          if (ca_pronto_in && (cnt_timeout != '0)) begin
            cnt_assentar <= 4'(LAT_EXTRA);
            estado       <= ST_ASSENTAR;
          end else if (cnt_timeout == TO_WIDTH'(TIMEOUT - 1)) begin
            erro_timeout_o <= 1'b1;
            estado         <= ST_OCIOSO;
          end else begin
            cnt_timeout <= cnt_timeout + 1'b1;
          end
        end
        ST_ASSENTAR: begin
          if (cnt_assentar == '0) begin
            res_criterio_r <= ca_criterio_geral_in;
            indice_busca   <= '0;
            estado         <= ST_BUSCAR;
          end else begin
            cnt_assentar <= cnt_assentar - 1'b1;
          end
        end
        ST_BUSCAR: begin
          if (snap_ativo[indice_busca] && slot_igual) begin
            res_indice_r <= indice_busca;
            res_vazio_r  <= 1'b0;
            res_valido_r <= 1'b1;
            estado       <= ST_ENTREGAR;
          end else if (indice_busca == IDX_WIDTH'(NUM_NA - 1)) begin
            res_indice_r <= '0;
            res_vazio_r  <= 1'b1;
            res_valido_r <= 1'b1;
            estado       <= ST_ENTREGAR;
          end else begin
            indice_busca <= indice_busca + 1'b1;
          end
        end
        ST_ENTREGAR: begin
          if (res.res_ack_in) begin
            res_valido_r <= 1'b0;
            estado       <= ST_OCIOSO;
          end
        end
        default: estado <= ST_OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_escalonador_classificacao.sv
// Directed + randomized bench for escalonador_classificacao with a
// behavioural classifier and a minimum/first-index reference model.
module tb_escalonador_classificacao;
  import escalonador_classificacao_pkg::*;

  localparam int NUM_NA = 8;
  localparam int CW     = 5;
  localparam int LAT    = 2;
  localparam int TMO    = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst = 1'b1;
  logic                sol_iniciar_in = 1'b0;
  logic                sol_cancelar_in = 1'b0;
  logic [NUM_NA-1:0]   na_ativo_in = '0;
  logic [NUM_NA*CW-1:0] na_criterio_in = '0;
  logic                ocupado_o;
  logic                aa_atualizar_o;
  logic [NUM_NA-1:0]   na_ativo_o;
  logic [NUM_NA*CW-1:0] na_criterio_o;
  logic                ca_pronto_in = 1'b0;
  logic [CW-1:0]       ca_criterio_geral_in = '0;
  logic                erro_timeout_o;
  estado_t             estado_o;

  escalonador_classificacao_if #(.IDX_WIDTH(3), .CRITERIO_WIDTH(CW)) res_if();

  escalonador_classificacao #(
    .NUM_NA(NUM_NA), .CRITERIO_WIDTH(CW), .LAT_EXTRA(LAT), .TIMEOUT(TMO)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .sol_iniciar_in       (sol_iniciar_in),
    .sol_cancelar_in      (sol_cancelar_in),
    .na_ativo_in          (na_ativo_in),
    .na_criterio_in       (na_criterio_in),
    .ocupado_o            (ocupado_o),
    .aa_atualizar_o       (aa_atualizar_o),
    .na_ativo_o           (na_ativo_o),
    .na_criterio_o        (na_criterio_o),
    .ca_pronto_in         (ca_pronto_in),
    .ca_criterio_geral_in (ca_criterio_geral_in),
    .res                  (res_if),
    .erro_timeout_o       (erro_timeout_o),
    .estado_o             (estado_o)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp_q[$];           // {vazio, criterio, indice}
  logic [CW-1:0] crit_q[NUM_NA];
  logic [CW-1:0] exp_min;
  int            exp_idx;
  logic          exp_vazio;
  logic [NUM_NA*CW-1:0] exp_masc;
  logic [8:0]    e_ult;

  // ---------------- classifier model + monitor ----------------
  int   ciclo = 0, ciclo_aa = 0, ciclo_valido = 0, ciclo_erro = 0;
  int   n_aa = 0, n_erro = 0, n_valid = 0;
  int   t = 0, atraso = 3;
  bit   rodando = 1'b0, nunca = 1'b0;
  logic [CW-1:0] min_mod = '0;
  logic valid_ant = 1'b0;

  // Classifier: stale pronto drops two cycles after the trigger; a new pronto
  // rises after 'atraso' cycles; the minimum is only correct in the single
  // cycle where the scheduler is due to sample it.
  always @(negedge clk) begin
    ciclo++;
    if (aa_atualizar_o) begin
      n_aa++;
      ciclo_aa = ciclo;
      t = 0;
      rodando = 1'b1;
    end else if (rodando) begin
      t++;
      if (t == 2) ca_pronto_in = 1'b0;
      if (!nunca) begin
        if (t == atraso) begin
          ca_pronto_in = 1'b1;
          ca_criterio_geral_in = min_mod ^ 5'h15;
        end
        if (t == atraso + LAT + 1) ca_criterio_geral_in = min_mod;
        if (t == atraso + LAT + 2) begin
          ca_criterio_geral_in = min_mod ^ 5'h15;
          rodando = 1'b0;
        end
      end
    end
    if (erro_timeout_o) begin
      n_erro++;
      ciclo_erro = ciclo;
    end
    if (res_if.res_valido_o) n_valid++;
    if (res_if.res_valido_o && !valid_ant) ciclo_valido = ciclo;
    valid_ant = res_if.res_valido_o;
  end

  // ---------------- driver / checker tasks ----------------
  task automatic passo();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: smallest criterion among active slots, lowest index wins ties.
  task automatic calcular_ref(input logic [NUM_NA-1:0] at);
    exp_vazio = 1'b1;
    exp_min   = 5'h1F;
    exp_idx   = 0;
    for (int i = 0; i < NUM_NA; i++) begin
      exp_masc[i*CW +: CW] = at[i] ? crit_q[i] : 5'h1F;
      if (at[i] && (exp_vazio || crit_q[i] < exp_min)) begin
        exp_min   = crit_q[i];
        exp_idx   = i;
        exp_vazio = 1'b0;
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ocupado"},  64'(ocupado_o), 64'(0));
    chk({tag, "_aa"},       64'(aa_atualizar_o), 64'(0));
    chk({tag, "_ativo_o"},  64'(na_ativo_o), 64'(0));
    chk({tag, "_crit_o"},   64'(na_criterio_o), 64'(40'hFF_FFFF_FFFF));
    chk({tag, "_valido"},   64'(res_if.res_valido_o), 64'(0));
    chk({tag, "_indice"},   64'(res_if.res_indice_o), 64'(0));
    chk({tag, "_criterio"}, 64'(res_if.res_criterio_o), 64'(0));
    chk({tag, "_vazio"},    64'(res_if.res_vazio_o), 64'(0));
    chk({tag, "_erro"},     64'(erro_timeout_o), 64'(0));
  endtask

  // Issues a request; returns on the cycle the trigger pulse is visible.
  task automatic iniciar(input logic [NUM_NA-1:0] at, input int d, input bit nv, input bit espera);
    calcular_ref(at);
    atraso  = d;
    nunca   = nv;
    min_mod = exp_min;
    if (espera) exp_q.push_back({exp_vazio, exp_min, 3'(exp_idx)});
    na_ativo_in = at;
    for (int i = 0; i < NUM_NA; i++) na_criterio_in[i*CW +: CW] = crit_q[i];
    sol_iniciar_in = 1'b1;
    passo();
    sol_iniciar_in = 1'b0;
    chk("ocupado_apos_inicio", 64'(ocupado_o), 64'(1));
    chk("snap_ativo", 64'(na_ativo_o), 64'(at));
    chk("snap_criterio", 64'(na_criterio_o), 64'(exp_masc));
    // Later input changes must not reach this run.
    na_ativo_in    = 8'($urandom);
    na_criterio_in = {8'($urandom), 32'($urandom)};
    passo();
    chk("pulso_atualizar", 64'(aa_atualizar_o), 64'(1));
  endtask

  task automatic aguardar_resultado();
    int k;
    int pos;
    k = 0;
    while (!res_if.res_valido_o && k < 100) begin
      passo();
      k++;
    end
    chk("resultado_no_prazo", 64'(res_if.res_valido_o), 64'(1));
    e_ult = exp_q.pop_front();
    pos = e_ult[8] ? NUM_NA - 1 : int'(e_ult[2:0]);
    chk("res_indice", 64'(res_if.res_indice_o), 64'(e_ult[2:0]));
    chk("res_criterio", 64'(res_if.res_criterio_o), 64'(e_ult[7:3]));
    chk("res_vazio", 64'(res_if.res_vazio_o), 64'(e_ult[8]));
    chk("latencia", 64'(ciclo_valido - ciclo_aa), 64'(5 + atraso + pos));
  endtask

  task automatic reconhecer();
    res_if.res_ack_in = 1'b1;
    passo();
    res_if.res_ack_in = 1'b0;
    chk("valido_cai", 64'(res_if.res_valido_o), 64'(0));
    chk("ocioso_apos_ack", 64'(ocupado_o), 64'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n_aa0, n_erro0, n_valid0, k;
    logic [NUM_NA-1:0] at;

    res_if.res_ack_in = 1'b0;
    rst = 1'b1;
    passo(); passo(); passo();
    chk_reset("reset");
    rst = 1'b0;
    passo();

    // 1: all active, tie on value 2 between slots 4 and 5.
    crit_q = '{5'd6, 5'd4, 5'd8, 5'd31, 5'd2, 5'd2, 5'd9, 5'd3};
    n_aa0 = n_aa;
    iniciar(8'hFF, 4, 1'b0, 1'b1);
    aguardar_resultado();
    chk("t1_um_pulso", 64'(n_aa - n_aa0), 64'(1));
    reconhecer();

    // 2: empty mask.
    for (int i = 0; i < NUM_NA; i++) crit_q[i] = 5'($urandom_range(0, 31));
    iniciar(8'h00, 3, 1'b0, 1'b1);
    chk("t2_masc_tudo_um", 64'(na_criterio_o), 64'(40'hFF_FFFF_FFFF));
    aguardar_resultado();
    reconhecer();

    // 3: inactive slot with the smallest raw value must be ignored.
    for (int i = 0; i < NUM_NA; i++) crit_q[i] = 5'd20;
    crit_q[3] = 5'd0;
    crit_q[6] = 5'd1;
    iniciar(8'b1111_0111, 5, 1'b0, 1'b1);
    chk("t3_slot3_mascarado", 64'(na_criterio_o[3*CW +: CW]), 64'(5'h1F));
    aguardar_resultado();
    reconhecer();

    // 4: classifier never answers; stale pronto is still high on entry.
    n_erro0  = n_erro;
    n_valid0 = n_valid;
    iniciar(8'hFF, 3, 1'b1, 1'b0);
    k = 0;
    while (n_erro == n_erro0 && k < 120) begin
      passo();
      k++;
    end
    passo(); passo(); passo();
    chk("t4_um_erro", 64'(n_erro - n_erro0), 64'(1));
    chk("t4_instante_erro", 64'(ciclo_erro - ciclo_aa), 64'(TMO + 1));
    chk("t4_ocioso", 64'(ocupado_o), 64'(0));
    chk("t4_sem_resultado", 64'(n_valid - n_valid0), 64'(0));

    // 5: ack withheld for 10 cycles, start pulses during the hold ignored.
    for (int i = 0; i < NUM_NA; i++) crit_q[i] = 5'($urandom_range(0, 15));
    n_aa0 = n_aa;
    iniciar(8'($urandom_range(1, 255)), 6, 1'b0, 1'b1);
    aguardar_resultado();
    for (int c = 0; c < 10; c++) begin
      sol_iniciar_in = 1'($urandom_range(0, 1));
      passo();
      chk("t5_valido_mantido", 64'(res_if.res_valido_o), 64'(1));
      chk("t5_indice_estavel", 64'(res_if.res_indice_o), 64'(e_ult[2:0]));
    end
    sol_iniciar_in = 1'b1;
    reconhecer();
    sol_iniciar_in = 1'b0;
    passo();
    chk("t5_inicio_nao_retido", 64'(ocupado_o), 64'(0));
    chk("t5_um_pulso", 64'(n_aa - n_aa0), 64'(1));

    // 6a: cancel while settling.
    for (int i = 0; i < NUM_NA; i++) crit_q[i] = 5'($urandom_range(0, 31));
    at = 8'($urandom_range(1, 255));
    n_valid0 = n_valid;
    iniciar(at, 4, 1'b0, 1'b0);
    k = 0;
    while (ciclo < ciclo_aa + 2 + 4 && k < 50) begin
      passo();
      k++;
    end
    sol_cancelar_in = 1'b1;
    passo();
    sol_cancelar_in = 1'b0;
    chk("t6_cancel_ocioso", 64'(ocupado_o), 64'(0));
    chk("t6_cancel_valido", 64'(res_if.res_valido_o), 64'(0));
    chk("t6_snapshot_mantido", 64'(na_ativo_o), 64'(at));
    for (int c = 0; c < 20; c++) passo();
    chk("t6_cancel_sem_resultado", 64'(n_valid - n_valid0), 64'(0));

    // 6b: reset in the middle of the scan.
    for (int i = 0; i < NUM_NA; i++) crit_q[i] = 5'd20;
    crit_q[7] = 5'd1;
    iniciar(8'hFF, 3, 1'b0, 1'b0);
    k = 0;
    while (ciclo < ciclo_aa + 6 + 3 && k < 50) begin
      passo();
      k++;
    end
    rst = 1'b1;
    passo();
    chk_reset("t6_reset_busca");
    rst = 1'b0;
    passo();
    chk("t6_reset_sem_resultado", 64'(n_valid - n_valid0), 64'(0));

    // 6c: a fresh request completes normally.
    for (int i = 0; i < NUM_NA; i++) crit_q[i] = 5'($urandom_range(0, 31));
    iniciar(8'($urandom_range(0, 255)), 3, 1'b0, 1'b1);
    aguardar_resultado();
    reconhecer();

    // Random runs with narrow criterion range to provoke ties.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < NUM_NA; i++) crit_q[i] = 5'($urandom_range(0, 7));
      at = 8'($urandom);
      if (r == 3) at = 8'h80;
      iniciar(at, $urandom_range(3, 7), 1'b0, 1'b1);
      aguardar_resultado();
      for (int c = 0; c < $urandom_range(0, 3); c++) passo();
      reconhecer();
      passo();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
